// File: rtl/mvu_agu_if.sv
// mvu_agu_if -- address bus between the address generator and its consumer.
//
// Signals:
//   addr_grnt : consumer accepts the current address (consumer -> AGU)
//   addr_en   : addr is valid                         (AGU -> consumer)
//   addr      : current data-bank address             (AGU -> consumer)
//   wrap0     : current beat is the last of the level-0 loop
//   wrap1     : current beat is the last of the level-1 loop
//
// Modports: master = address generator side, slave = consumer side.
interface mvu_agu_if #(
    parameter int BADDR = 15
);
    logic             addr_grnt;
    logic             addr_en;
    logic [BADDR-1:0] addr;
    logic             wrap0;
    logic             wrap1;

    modport master (
        input  addr_grnt,
        output addr_en,
        output addr,
        output wrap0,
        output wrap1
    );

    modport slave (
        output addr_grnt,
        input  addr_en,
        input  addr,
        input  wrap0,
        input  wrap1
    );
endinterface

// File: rtl/mvu_agu.sv
// mvu_agu -- three-level nested-loop address generator.
//
// A job walks an address pattern built from three nested loops. Level 0
// steps by stride_0 for length_0 beats, then level 1 adds stride_1 and
// restarts level 0, and so on up to level 2. When every level is exhausted
// the pattern restarts from baseaddr. The job ends after countdown beats.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : job start request, sampled only in IDLE
//   countdown  : number of address beats in the job
//   baseaddr   : first address of the pattern
//   stride_0/1/2 : two's-complement increments per loop level
//   length_0/1/2 : loop reload values per level
//   bus        : address bus (master side), see mvu_agu_if
//   busy       : a job is in progress (RUN or DONE)
//   done       : one-cycle job-complete pulse
module mvu_agu #(
    parameter int BADDR   = 15,
    parameter int BLEN    = 32,
    parameter int BCNTDWN = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BCNTDWN-1:0] countdown,
    input  logic [BADDR-1:0]   baseaddr,
    input  logic [BADDR-1:0]   stride_0,
    input  logic [BADDR-1:0]   stride_1,
    input  logic [BADDR-1:0]   stride_2,
    input  logic [BLEN-1:0]    length_0,
    input  logic [BLEN-1:0]    length_1,
    input  logic [BLEN-1:0]    length_2,
    mvu_agu_if.master          bus,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Job configuration, captured when start is accepted.
    logic [BADDR-1:0]   base_q;
    logic [BADDR-1:0]   s0_q, s1_q, s2_q;
    logic [BLEN-1:0]    l0_q, l1_q, l2_q;

    // Walk state.
    logic [BADDR-1:0]   addr_q;
    logic [BLEN-1:0]    c0, c1, c2;
    logic [BCNTDWN-1:0] remaining;

    logic addr_en;
    logic beat;
    logic last_beat;

    assign beat      = addr_en && bus.addr_grnt;
    assign last_beat = beat && (remaining == BCNTDWN'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so that no
        // path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        addr_en   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (countdown != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                addr_en = 1'b1;
                busy    = 1'b1;
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: config capture and the nested-loop walk.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            base_q    <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            l0_q      <= '0;
            l1_q      <= '0;
            l2_q      <= '0;
            addr_q    <= '0;
            c0        <= '0;
            c1        <= '0;
            c2        <= '0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            base_q    <= baseaddr;
            s0_q      <= stride_0;
            s1_q      <= stride_1;
            s2_q      <= stride_2;
            l0_q      <= length_0;
            l1_q      <= length_1;
            l2_q      <= length_2;
            addr_q    <= baseaddr;
            c0        <= length_0;
            c1        <= length_1;
            c2        <= length_2;
            remaining <= countdown;
        end else if (beat) begin
            remaining <= remaining - BCNTDWN'(1);
            // Innermost non-exhausted level advances; every level inside
            // it is reloaded. Address sums wrap silently at 2^BADDR.
            if (c0 != '0) begin
                addr_q <= addr_q + s0_q;
                c0     <= c0 - BLEN'(1);
            end else if (c1 != '0) begin
                addr_q <= addr_q + s1_q;
                c0     <= l0_q;
                c1     <= c1 - BLEN'(1);
            end else if (c2 != '0) begin
                addr_q <= addr_q + s2_q;
                c0     <= l0_q;
                c1     <= l1_q;
                c2     <= c2 - BLEN'(1);
            end else begin
                addr_q <= base_q;
                c0     <= l0_q;
                c1     <= l1_q;
                c2     <= l2_q;
            end
        end
    end

    assign bus.addr_en = addr_en;
    assign bus.addr    = addr_q;
    assign bus.wrap0   = addr_en && (c0 == '0);
    assign bus.wrap1   = addr_en && (c0 == '0) && (c1 == '0);

endmodule

// File: doc/mvu_agu.md
MVU_AGU -- requirements
Module: mvu_agu

Interface
REQ-001 SHALL have parameter BADDR, default 15, meaning the address width (data-bank address).
REQ-002 SHALL have parameter BLEN, default 32, meaning the loop-length width.
REQ-003 SHALL have parameter BCNTDWN, default 29, meaning the countdown width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: job start request, sampled only in IDLE.
REQ-007 SHALL have port countdown, input, BCNTDWN bits: number of address beats in the job.
REQ-008 SHALL have port baseaddr, input, BADDR bits: first address of the pattern.
REQ-009 SHALL have ports stride_0, stride_1 and stride_2, inputs, BADDR bits each: two's-complement address increments per loop level.
REQ-010 SHALL have ports length_0, length_1 and length_2, inputs, BLEN bits each: loop reload values per level.
REQ-011 SHALL have port addr_grnt, input, 1 bit: consumer accepts the current address.
REQ-012 SHALL have port addr_en, output, 1 bit: addr is valid.
REQ-013 SHALL have port addr, output, BADDR bits: current address.
REQ-014 SHALL have port wrap0, output, 1 bit: the current beat is the last beat of the level-0 loop.
REQ-015 SHALL have port wrap1, output, 1 bit: the current beat is the last beat of the level-1 loop.
REQ-016 SHALL have port busy, output, 1 bit: a job is in progress.
REQ-017 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.

Function
REQ-018 SHALL implement exactly three states: IDLE, RUN, DONE.
REQ-019 SHALL, in IDLE with start=1, latch all config inputs; next state is RUN if countdown!=0, else DONE.
REQ-020 SHALL, on entering RUN, set addr=baseaddr, c0=length_0, c1=length_1, c2=length_2, and remaining=countdown, then assert addr_en in the cycle after start is sampled.
REQ-021 SHALL define a beat as a cycle with addr_en=1 and addr_grnt=1; without a beat, addr, the counters and remaining hold.
REQ-022 SHALL, on a beat with c0!=0, set addr+=stride_0 and decrement c0.
REQ-023 SHALL, on a beat with c0==0 and c1!=0, set addr+=stride_1, reload c0, and decrement c1.
REQ-024 SHALL, on a beat with c0==0, c1==0 and c2!=0, set addr+=stride_2, reload c0 and c1, and decrement c2.
REQ-025 SHALL, on a beat with c0==c1==c2==0, set addr=baseaddr and reload all counters, repeating the pattern.
REQ-026 SHALL drive wrap0=addr_en&&(c0==0) and wrap1=addr_en&&(c0==0)&&(c1==0) combinationally.
REQ-027 SHALL perform all address arithmetic modulo 2^BADDR, so that wrap-around is silent.
REQ-028 SHALL decrement remaining on every beat; a beat with remaining==1 moves to DONE, and addr_en drops in the next cycle.
REQ-029 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-030 SHALL drive busy=1 in RUN and DONE only.
REQ-031 SHALL ignore start while not in IDLE, and SHALL not modify the latched config.
REQ-032 SHALL, in IDLE, drive addr_en=0 and hold addr at its last value.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, enter IDLE and set addr=0, addr_en=0, busy=0, done=0 and counters=0, with wrap0=wrap1=0.
REQ-034 SHALL give rst priority over start and beats, including mid-RUN, where it aborts the job with no done pulse.

Verification
REQ-035 SHALL pass a 1D test: base=100, stride_0=1, length_0=3, length_1=length_2=0, countdown=8, grnt=1 -> addr 100,101,102,103,100,101,102,103; wrap0 on both 103 beats; done in the cycle after the last beat.
REQ-036 SHALL pass a 2D test: base=0, length_0=1, stride_0=1, length_1=2, stride_1=8, length_2=0, countdown=6 -> addr 0,1,9,10,18,19; wrap0 on 1,10,19; wrap1 on 19.
REQ-037 SHALL pass a stall test: in the 1D setup, grnt=0 for 2 cycles after beat 101 -> addr holds 102 with addr_en=1, and the job completes 2 cycles later with an identical address sequence.
REQ-038 SHALL pass a zero-count test: countdown=0 with a start pulse -> addr_en never asserted and done=1 in the cycle after start.
REQ-039 SHALL pass a reset-and-restart test: rst in the 3rd RUN cycle -> the next cycle has busy=0, addr_en=0, addr=0 and no done; a start pulse during RUN changes nothing.
REQ-040 SHALL pass a wrap test: BADDR=15, base=0x7FFE, stride_0=1, length_0=5, countdown=3 -> addr 0x7FFE, 0x7FFF, 0x0000.
